// File: rtl/spi_sck_gen.sv
// spi_sck_gen
//   SPI master serial-clock controller. Runs from clk and produces SCK plus
//   one-cycle Shift_en / Sample_en strobes for all four CPOL/CPHA modes. A
//   programmable half-period divider and a frame-length edge counter are built
//   in, so no external baud clock is needed.
//
//   Optional feature macro: SPI_SCK_ABORT_EN (adds abort / aborted ports).
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   CPOL       clock polarity (idle SCK level)
//   CPHA       clock phase
//   BaudDiv    SCK half-period minus one, in clk cycles
//   FrameLen   bits per frame, 1..MAX_BITS (other values: start ignored)
//   start      request one frame, sampled only in IDLE
//   abort      (SPI_SCK_ABORT_EN) cancel the running frame
//   aborted    (SPI_SCK_ABORT_EN) 1-cycle pulse after an abort
//   busy       frame in progress
//   SCK_out    serial clock to the pad
//   Shift_en   1-cycle strobe: drive next MOSI bit
//   Sample_en  1-cycle strobe: capture MISO bit
//   done       1-cycle pulse at frame completion
//
// state  | meaning
// IDLE   | SCK follows CPOL, waiting for a valid start
// ACTIVE | toggling SCK every BaudDiv_l+1 cycles, 2*FrameLen_l edges
// GUARD  | SCK held at CPOL_l for one half-period, then done

module spi_sck_gen #(
  parameter int DIV_W    = 8,
  parameter int MAX_BITS = 32,
  parameter int LEN_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CPOL,
  input  logic             CPHA,
  input  logic [DIV_W-1:0] BaudDiv,
  input  logic [LEN_W-1:0] FrameLen,
  input  logic             start,
`ifdef SPI_SCK_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             SCK_out,
  output logic             Shift_en,
  output logic             Sample_en,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, GUARD = 2'd2} state_t;

  localparam logic [LEN_W:0] MAX_L = (LEN_W+1)'(MAX_BITS);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, div_l;
  logic [LEN_W:0]   edge_cnt, edge_num;
  logic [LEN_W-1:0] len_l;
  logic             cpol_l, cpha_l;
  logic             tc, last_edge, len_ok, abort_hit;
  logic             sck_nxt, shift_nxt, sample_nxt, done_nxt, busy_nxt;

  assign tc        = (cnt == div_l);
  assign edge_num  = edge_cnt + 1'b1;          // number of the edge taken at this tc
  assign last_edge = (edge_num == {len_l, 1'b0});
  assign len_ok    = (FrameLen != '0) && ({1'b0, FrameLen} <= MAX_L);

`ifdef SPI_SCK_ABORT_EN
  logic aborted_nxt;
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state logic. A start in the cycle where done is showing is refused,
  // so a back-to-back frame is accepted one cycle later.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !done && len_ok) state_nxt = ACTIVE;
      ACTIVE:  if (tc && last_edge)          state_nxt = GUARD;
      GUARD:   if (tc)                       state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  // Output next-values; all outputs are registered in the sequential block.
  always_comb begin
    sck_nxt    = SCK_out;
    shift_nxt  = 1'b0;
    sample_nxt = 1'b0;
    done_nxt   = 1'b0;
    busy_nxt   = busy;
    case (state)
      IDLE: begin
        sck_nxt  = CPOL;
        busy_nxt = (state_nxt == ACTIVE);
      end
      ACTIVE: begin
        if (tc) begin
          sck_nxt = ~SCK_out;
          if (cpha_l) begin
            shift_nxt  = edge_num[0];
            sample_nxt = ~edge_num[0];
          end else begin
            // first bit is preloaded on start, so no shift after the final edge
            sample_nxt = edge_num[0];
            shift_nxt  = ~edge_num[0] && !last_edge;
          end
        end
      end
      GUARD: begin
        sck_nxt = cpol_l;
        if (tc) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end
      end
      default: sck_nxt = cpol_l;
    endcase
    if (abort_hit) begin
      sck_nxt    = cpol_l;
      shift_nxt  = 1'b0;
      sample_nxt = 1'b0;
      done_nxt   = 1'b0;
      busy_nxt   = 1'b0;
    end
`ifdef SPI_SCK_ABORT_EN
    aborted_nxt = abort_hit;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      edge_cnt  <= '0;
      div_l     <= '0;
      len_l     <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      SCK_out   <= 1'b0;
      Shift_en  <= 1'b0;
      Sample_en <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
`ifdef SPI_SCK_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      SCK_out   <= sck_nxt;
      Shift_en  <= shift_nxt;
      Sample_en <= sample_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
`ifdef SPI_SCK_ABORT_EN
      aborted   <= aborted_nxt;
`endif
      case (state)
        IDLE: begin
          cnt      <= '0;
          edge_cnt <= '0;
          if (state_nxt == ACTIVE) begin
            cpol_l <= CPOL;
            cpha_l <= CPHA;
            div_l  <= BaudDiv;
            len_l  <= FrameLen;
          end
        end
        ACTIVE: begin
          if (tc) begin
            cnt      <= '0;
            edge_cnt <= edge_num;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GUARD:   cnt <= tc ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
      if (abort_hit) begin
        cnt      <= '0;
        edge_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_sck_gen.sv
// Testbench for spi_sck_gen: directed frame table with expected totals, a few
// hand-written corner sequences, and random frames checked cycle by cycle
// against an arithmetic model of the SCK waveform.
module tb_spi_sck_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       CPOL, CPHA, start;
  logic [7:0] BaudDiv;
  logic [5:0] FrameLen;
  logic       busy, SCK_out, Shift_en, Sample_en, done;
`ifdef SPI_SCK_ABORT_EN
  logic       abort, aborted;
`endif

  int vectors     = 0;
  int miscompares = 0;

  spi_sck_gen dut (
    .clk       (clk),
    .rst       (rst),
    .CPOL      (CPOL),
    .CPHA      (CPHA),
    .BaudDiv   (BaudDiv),
    .FrameLen  (FrameLen),
    .start     (start),
`ifdef SPI_SCK_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .busy      (busy),
    .SCK_out   (SCK_out),
    .Shift_en  (Shift_en),
    .Sample_en (Sample_en),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit cpol;
    bit cpha;
    int div;
    int len;
    int exp_busy;
    int exp_samp;
    int exp_shift;
    int exp_edges;
  } frame_vec_t;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {busy, SCK_out, Shift_en, Sample_en, done}
  task automatic chk_vec(input string name, input int k, input logic [4:0] exp);
    logic [4:0] act;
    act = {busy, SCK_out, Shift_en, Sample_en, done};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s k=%0d: got busy/sck/shift/samp/done=%b, expected %b (t=%0t)",
               name, k, act, exp, $time);
    end
  endtask

  // Run one valid frame, compare every cycle against the waveform model, and
  // return observed totals. With junk=1 the inputs are scrambled while busy.
  task automatic run_frame(input string name, input bit cpol, input bit cpha,
                           input int div, input int len, input bit junk,
                           output int n_busy, output int n_samp,
                           output int n_shift, output int n_edge);
    int   half, donek, ek, lvl;
    bit   cpol_drv, e_busy, e_sck, e_shift, e_samp, e_done, prev_sck;
    half  = div + 1;
    donek = (2*len + 1) * half;
    n_busy = 0; n_samp = 0; n_shift = 0; n_edge = 0;
    CPOL = cpol; CPHA = cpha; BaudDiv = 8'(div); FrameLen = 6'(len); start = 1'b1;
    cpol_drv = cpol;
    prev_sck = cpol;
    for (int k = 0; k <= donek + 1; k++) begin
      @(posedge clk); #1;
      lvl     = (k / half > 2*len) ? 2*len : k / half;
      ek      = (k % half == 0 && k >= half && k <= 2*len*half) ? k / half : 0;
      e_busy  = (k < donek);
      e_done  = (k == donek);
      e_sck   = (k <= donek) ? (cpol ^ lvl[0]) : cpol_drv;
      e_shift = 1'b0;
      e_samp  = 1'b0;
      if (ek != 0) begin
        if (cpha) begin
          e_shift = ek[0];
          e_samp  = !ek[0];
        end else begin
          e_samp  = ek[0];
          e_shift = !ek[0] && (ek != 2*len);
        end
      end
      chk_vec(name, k, {e_busy, e_sck, e_shift, e_samp, e_done});
      if (busy) n_busy++;
      if (Sample_en) n_samp++;
      if (Shift_en) n_shift++;
      if (k >= 1 && k <= donek && SCK_out != prev_sck) n_edge++;
      prev_sck = SCK_out;
      if (junk && k <= donek) begin
        CPOL     = 1'($urandom);
        CPHA     = 1'($urandom);
        BaudDiv  = 8'($urandom);
        FrameLen = 6'($urandom);
        start    = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      cpol_drv = CPOL;
    end
    start = 1'b0;
  endtask

  task automatic invalid_start(input int len, input bit cpol);
    CPOL = cpol; CPHA = 1'($urandom); BaudDiv = 8'($urandom_range(0, 3));
    FrameLen = 6'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_vec("invalid_len_ignored", i, {1'b0, cpol, 3'b000});
      @(posedge clk); #1;
    end
  endtask

  frame_vec_t tbl[4];

  initial begin
    int nb, ns, nsh, ne, strobes;
    tbl[0] = '{cpol:0, cpha:0, div:3, len:8,  exp_busy:68,  exp_samp:8,  exp_shift:7,  exp_edges:16};
    tbl[1] = '{cpol:1, cpha:1, div:0, len:1,  exp_busy:3,   exp_samp:1,  exp_shift:1,  exp_edges:2};
    tbl[2] = '{cpol:0, cpha:1, div:1, len:32, exp_busy:130, exp_samp:32, exp_shift:32, exp_edges:64};
    tbl[3] = '{cpol:1, cpha:0, div:1, len:32, exp_busy:130, exp_samp:32, exp_shift:31, exp_edges:64};

    rst = 1'b1; CPOL = 1'b1; CPHA = 1'b0; BaudDiv = 8'd0; FrameLen = 6'd0; start = 1'b0;
`ifdef SPI_SCK_ABORT_EN
    abort = 1'b0;
`endif
    #1;
    chk_vec("reset_values", 0, 5'b00000);
    #20;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_vec("idle_sck_follows_cpol", 0, 5'b01000);

    // directed frame table
    foreach (tbl[i]) begin
      run_frame("table_frame", tbl[i].cpol, tbl[i].cpha, tbl[i].div, tbl[i].len, 1'b0,
                nb, ns, nsh, ne);
      chk("table_busy_cycles", nb, tbl[i].exp_busy);
      chk("table_sample_count", ns, tbl[i].exp_samp);
      chk("table_shift_count", nsh, tbl[i].exp_shift);
      chk("table_sck_edges", ne, tbl[i].exp_edges);
    end

    // FrameLen=0 ignored, then a frame with start/config churn while busy
    invalid_start(0, 1'b0);
    invalid_start(33, 1'b1);
    run_frame("churn_frame", 1'b0, 1'b0, 2, 4, 1'b1, nb, ns, nsh, ne);
    chk("churn_sample_count", ns, 4);
    chk("churn_shift_count", nsh, 3);

    // asynchronous reset after edge 5 of a mode-0 frame
    CPOL = 1'b0; CPHA = 1'b0; BaudDiv = 8'd3; FrameLen = 6'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk_vec("edge5_before_reset", 20, 5'b11010);
    #2 rst = 1'b1;
    #1;
    chk_vec("async_reset_outputs", 0, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_done_in_reset", int'(done), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame("post_reset_frame", 1'b0, 1'b0, 3, 8, 1'b0, nb, ns, nsh, ne);
    chk("post_reset_busy", nb, 68);

`ifdef SPI_SCK_ABORT_EN
    // abort ignored in IDLE
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle_ignored", int'(aborted), 0);
    // abort landing on edge 3
    CPOL = 1'b1; CPHA = 1'b0; BaudDiv = 8'd2; FrameLen = 6'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    strobes = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      strobes += int'(Shift_en) + int'(Sample_en);
    end
    CPOL = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_pulse", int'(aborted), 1);
    chk_vec("abort_outputs", 9, 5'b01000);
    strobes += int'(Shift_en) + int'(Sample_en);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      strobes += int'(Shift_en) + int'(Sample_en);
      if (done || aborted) chk("abort_no_done_no_repeat", int'({done, aborted}), 0);
    end
    chk("abort_strobe_count", strobes, 2);
    CPOL = 1'b1;
`else
    strobes = 0;
`endif

    // random frames against the model
    for (int it = 0; it < 40; it++) begin
      int d, l;
      d = $urandom_range(0, 4);
      l = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 32);
      if ($urandom_range(0, 3) == 0)
        invalid_start(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63), 1'($urandom));
      run_frame("random_frame", 1'($urandom), 1'($urandom), d, l, 1'($urandom), nb, ns, nsh, ne);
      chk("random_sample_count", ns, l);
      chk("random_busy_cycles", nb, (2*l + 1) * (d + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
